seq_divider: RTL and testbench

Sequential restoring divider: the inverse of the team's combinational multiplier. It takes an N-bit dividend, such as a multiplier product, and an M-bit divisor, and returns the quotient and remainder. It produces one quotient bit per clock under a start/done handshake. It sits beside the multiplier in the arithmetic lab set and is verified by checking that multiplying its results back gives the original operands.

---
 rtl/arith_pkg.sv | 17 +
 rtl/div_step.sv | 36 +++
 rtl/seq_divider.sv | 133 +++++++++++++
 tb/tb_seq_divider.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Purpose: shared types and default widths for the arithmetic lab blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arith_pkg;

   // Default operand widths for the sequential divider.
   localparam int DIV_N = 4;
   localparam int DIV_M = 2;

   // Divider control states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/div_step.sv
// Purpose: one combinational restoring-division step (shift in a dividend bit, trial subtract).
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
//
// Ports:
//   rem_in  [M:0]   partial remainder before the step
//   dvd_bit         next dividend bit, MSB first
//   divisor [M-1:0] divisor
//   rem_out [M:0]   partial remainder after the step
//   q_bit           quotient bit produced by this step
module div_step
   import arith_pkg::*;
#(
   parameter int M = DIV_M
) (
   input  logic [M:0]   rem_in,
   input  logic         dvd_bit,
   input  logic [M-1:0] divisor,
   output logic [M:0]   rem_out,
   output logic         q_bit
);

   logic [M:0] trial;
   logic [M:0] divisor_ext;

   always_comb begin
      divisor_ext = {1'b0, divisor};
      trial       = {rem_in[M-1:0], dvd_bit};
      // The full shifted value is {rem_in, dvd_bit}; if rem_in[M] were set it
      // would exceed any M-bit divisor, so it forces a subtract. In normal
      // operation the incoming remainder is below the divisor and this bit is 0.
      q_bit   = rem_in[M] | (trial >= divisor_ext);
      rem_out = q_bit ? (trial - divisor_ext) : trial;
   end

endmodule

// File: rtl/seq_divider.sv
// Purpose: sequential restoring divider, one quotient bit per clock, start/done handshake.
// Latency: N+1 cycles from accepted start to done; 1 cycle for divide-by-zero.
// Backpressure: start is ignored while busy; results held until the next accepted start.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start              request a division (accepted in IDLE or DONE)
//   dividend [N-1:0]   operand A, captured on an accepted start
//   divisor  [M-1:0]   operand B, captured on an accepted start
//   busy               high while a division is in progress
//   done               one-cycle pulse when the results are valid
//   quotient [N-1:0]   result, held until the next accepted start
//   remainder[M-1:0]   result, held until the next accepted start
//   dbz                divide-by-zero flag, valid with done
module seq_divider
   import arith_pkg::*;
#(
   parameter int N = DIV_N,
   parameter int M = DIV_M
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [M-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic [M-1:0] remainder,
   output logic         dbz
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;

   div_state_t state, next_state;

   logic [N-1:0]  dvd_sh;     // dividend bits still to be consumed, MSB first
   logic [M-1:0]  div_q;      // captured divisor
   logic [M:0]    rem_q;      // partial remainder
   logic [N-1:0]  q_sh;       // quotient bits accumulated so far
   logic [CW-1:0] cnt;        // steps remaining minus one

   logic          accept;
   logic          last_step;
   logic [M:0]    step_rem;
   logic          step_q;
   logic [N-1:0]  q_next;

   div_step #(.M(M)) u_step (
      .rem_in  (rem_q),
      .dvd_bit (dvd_sh[N-1]),
      .divisor (div_q),
      .rem_out (step_rem),
      .q_bit   (step_q)
   );

   // A new division can begin from IDLE, or from DONE for back-to-back use.
   assign accept    = start && (state != RUN);
   assign last_step = (state == RUN) && (cnt == '0);
   assign q_next    = (q_sh << 1) | N'(step_q);

   // Outputs decode straight from registers only.
   assign busy = (state == RUN);
   assign done = (state == DONE);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               next_state = (divisor == '0) ? DONE : RUN;
            end else begin
               next_state = IDLE;
            end
         end
         RUN: begin
            if (cnt == '0) begin
               next_state = DONE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Datapath and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         dvd_sh    <= '0;
         div_q     <= '0;
         rem_q     <= '0;
         q_sh      <= '0;
         cnt       <= '0;
         quotient  <= '0;
         remainder <= '0;
         dbz       <= 1'b0;
      end else if (accept) begin
         dvd_sh <= dividend;
         div_q  <= divisor;
         rem_q  <= '0;
         q_sh   <= '0;
         cnt    <= CW'(N - 1);
         if (divisor == '0) begin
            // Divide-by-zero finishes immediately with a saturated quotient.
            quotient  <= '1;
            remainder <= '0;
            dbz       <= 1'b1;
         end else begin
            // Previous results stay visible until this division completes.
            dbz <= 1'b0;
         end
      end else if (state == RUN) begin
         rem_q  <= step_rem;
         q_sh   <= q_next;
         dvd_sh <= dvd_sh << 1;
         cnt    <= cnt - CW'(1);
         if (last_step) begin
            quotient  <= q_next;
            remainder <= step_rem[M-1:0];
         end
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] dividend;
   logic [1:0] divisor;
   logic       busy;
   logic       done;
   logic [3:0] quotient;
   logic [1:0] remainder;
   logic       dbz;

   int checks;
   int errors;

   seq_divider #(.N(4), .M(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .dbz       (dbz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called at a negedge: present operands with start for one edge.
   task automatic launch(input logic [3:0] a, input logic [1:0] b);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
   endtask

   // Entered at the negedge one cycle after the accepting edge (cycle 1).
   task automatic wait_done(output int cyc, output int bcnt);
      cyc  = 1;
      bcnt = 0;
      while (done !== 1'b1 && cyc < 30) begin
         if (busy === 1'b1) bcnt++;
         @(negedge clk);
         cyc++;
      end
      if (done !== 1'b1) chk("done_timeout", 32'(done), 32'd1);
   endtask

   task automatic div_check(input logic [3:0] a, input logic [1:0] b,
                            input int eq, input int er);
      int cyc, bcnt;
      launch(a, b);
      wait_done(cyc, bcnt);
      chk("quotient", 32'(quotient), eq);
      chk("remainder", 32'(remainder), er);
      chk("dbz", 32'(dbz), 0);
      chk("latency", cyc, 5);
   endtask

   initial begin
      int cyc, bcnt;
      logic [5:0] prod;
      checks   = 0;
      errors   = 0;
      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(negedge clk);

      // Reset state
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_quotient", 32'(quotient), 0);
      chk("rst_remainder", 32'(remainder), 0);
      chk("rst_dbz", 32'(dbz), 0);
      rst = 1'b0;
      @(negedge clk);

      // 9 / 2 = 4 r1, done 5 cycles after start, busy for exactly 4 cycles
      launch(4'd9, 2'd2);
      chk("busy_after_start", 32'(busy), 1);
      wait_done(cyc, bcnt);
      chk("q_9_2", 32'(quotient), 4);
      chk("r_9_2", 32'(remainder), 1);
      chk("dbz_9_2", 32'(dbz), 0);
      chk("lat_9_2", cyc, 5);
      chk("busycnt_9_2", bcnt, 4);
      chk("busy_in_done", 32'(busy), 0);
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 0);
      chk("idle_busy", 32'(busy), 0);
      chk("q_held", 32'(quotient), 4);

      // Multiplier products and full-range operands
      div_check(4'd9, 2'd3, 3, 0);
      div_check(4'd6, 2'd2, 3, 0);
      div_check(4'd15, 2'd3, 5, 0);
      div_check(4'd15, 2'd2, 7, 1);
      div_check(4'd0, 2'd1, 0, 0);
      div_check(4'd2, 2'd3, 0, 2);

      // Invariant sweep over every nonzero-divisor pair
      for (int a = 0; a < 16; a++) begin
         for (int b = 1; b < 4; b++) begin
            launch(4'(a), 2'(b));
            wait_done(cyc, bcnt);
            prod = 6'(quotient) * 6'(divisor) + 6'(remainder);
            chk("inv_product", 32'(prod), a);
            chk("inv_rem_lt_div", 32'(remainder < 2'(b)), 1);
            chk("inv_quotient", 32'(quotient), a / b);
         end
      end

      // Divide by zero: done next cycle, busy never high
      launch(4'd7, 2'd0);
      wait_done(cyc, bcnt);
      chk("dbz_lat", cyc, 1);
      chk("dbz_busycnt", bcnt, 0);
      chk("dbz_busy", 32'(busy), 0);
      chk("dbz_q", 32'(quotient), 15);
      chk("dbz_r", 32'(remainder), 0);
      chk("dbz_flag", 32'(dbz), 1);
      @(negedge clk);
      chk("dbz_held", 32'(dbz), 1);
      // A later normal division clears the flag
      div_check(4'd9, 2'd2, 4, 1);

      // Start while busy is ignored
      launch(4'd9, 2'd2);
      @(negedge clk);
      dividend = 4'd15;
      divisor  = 2'd3;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      wait_done(cyc, bcnt);
      chk("ignore_lat", cyc + 2, 5);
      chk("ignore_q", 32'(quotient), 4);
      chk("ignore_r", 32'(remainder), 1);
      @(negedge clk);
      chk("ignore_no_restart", 32'(busy), 0);

      // Back-to-back: start held across the done cycle
      dividend = 4'd9;
      divisor  = 2'd2;
      start    = 1'b1;
      @(negedge clk);
      dividend = 4'd14;
      divisor  = 2'd3;
      wait_done(cyc, bcnt);
      chk("b2b_first_lat", cyc, 5);
      chk("b2b_first_q", 32'(quotient), 4);
      chk("b2b_first_r", 32'(remainder), 1);
      @(negedge clk);
      start = 1'b0;
      chk("b2b_no_gap_busy", 32'(busy), 1);
      chk("b2b_no_gap_done", 32'(done), 0);
      wait_done(cyc, bcnt);
      chk("b2b_second_lat", cyc, 5);
      chk("b2b_second_q", 32'(quotient), 4);
      chk("b2b_second_r", 32'(remainder), 2);

      // Reset during a run
      launch(4'd9, 2'd2);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_done", 32'(done), 0);
      chk("mid_rst_q", 32'(quotient), 0);
      chk("mid_rst_r", 32'(remainder), 0);
      chk("mid_rst_dbz", 32'(dbz), 0);
      rst = 1'b0;
      @(negedge clk);
      repeat (6) begin
         @(negedge clk);
         chk("post_rst_quiet", 32'(busy | done), 0);
      end
      div_check(4'd8, 2'd2, 4, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
